// File: rtl/core_mon_pkg.sv
// Shared definitions for the core trace monitor: instruction encodings, default widths and
// the trace-entry layout.
package core_mon_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned CNT_W_DEF = 32;

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ECALL  = 32'h0000_0073;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] ir;
   } trace_entry_t;

endpackage

// File: rtl/mon_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO with no pop is dropped and
// flagged through a sticky overflow bit.
module mon_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             overflow_o
);

   localparam int unsigned Aw = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [Aw:0]      wptr_q, wptr_d;
   logic [Aw:0]      rptr_q, rptr_d;
   logic             ovf_q, ovf_d;
   logic             empty, full, pop_en, push_en;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);

   // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
   assign pop_en  = pop_i && !empty;
   assign push_en = push_i && (!full || pop_en);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      if (push_en) wptr_d = wptr_q + 1'b1;
      if (pop_en)  rptr_d = rptr_q + 1'b1;
      if (push_i && !push_en) ovf_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && push_en) mem_q[wptr_q[Aw-1:0]] <= data_i;
   end

   assign valid_o    = !empty;
   assign data_o     = empty ? '0 : mem_q[rptr_q[Aw-1:0]];
   assign overflow_o = ovf_q;

endmodule

// File: rtl/core_trace_monitor.sv
// Retire-stage observability: cycle/instret counters, shadow GPRs, halt detection and an
// optional PC/IR trace FIFO built only when CORE_MON_TRACE_EN is defined.
module core_trace_monitor
   import core_mon_pkg::*;
#(
   parameter int unsigned XLEN      = XLEN_DEF,
   parameter int unsigned NREG      = 16,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned HALT_LOOP = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ret_valid,
   input  logic [XLEN-1:0]         ret_pc,
   input  logic [XLEN-1:0]         ret_ir,
   input  logic                    wb_we,
   input  logic [4:0]              wb_addr,
   input  logic [XLEN-1:0]         wb_data,
   input  logic [$clog2(NREG)-1:0] dbg_addr,
   output logic [XLEN-1:0]         dbg_data,
   output logic                    tr_valid,
   input  logic                    tr_ready,
   output logic [XLEN-1:0]         tr_pc,
   output logic [XLEN-1:0]         tr_ir,
   output logic                    tr_overflow,
   output logic [CNT_W-1:0]        cycle_cnt,
   output logic [CNT_W-1:0]        instr_cnt,
   output logic                    halted
);

   localparam int unsigned RegAw = $clog2(NREG);

   logic [XLEN-1:0]  shadow_q [NREG];
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instr_q, instr_d;
   logic [3:0]       rep_q, rep_d;
   logic [XLEN-1:0]  last_pc_q, last_pc_d;
   logic             halted_q, halted_d;
   logic             capture, shadow_we;

   assign capture   = ret_valid && !halted_q;
   // x0 is never written, so it keeps its reset value of zero.
   assign shadow_we = wb_we && (wb_addr != 5'd0) && ({1'b0, wb_addr} < 6'(NREG)) && !halted_q;

   // rep_q starts at 0, so the first retirement after reset lands on 1 whatever its PC.
   always_comb begin
      cycle_d   = cycle_q;
      instr_d   = instr_q;
      rep_d     = rep_q;
      last_pc_d = last_pc_q;
      halted_d  = halted_q;
      if (!halted_q) begin
         cycle_d = cycle_q + CNT_W'(1);
         if (ret_valid) begin
            instr_d   = instr_q + CNT_W'(1);
            last_pc_d = ret_pc;
            rep_d     = (ret_pc == last_pc_q) ? rep_q + 4'd1 : 4'd1;
            if ((ret_ir == XLEN'(EBREAK)) || (rep_d == 4'(HALT_LOOP))) halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q   <= '0;
         instr_q   <= '0;
         rep_q     <= '0;
         last_pc_q <= '0;
         halted_q  <= 1'b0;
      end else begin
         cycle_q   <= cycle_d;
         instr_q   <= instr_d;
         rep_q     <= rep_d;
         last_pc_q <= last_pc_d;
         halted_q  <= halted_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '{default: '0};
      end else if (shadow_we) begin
         shadow_q[wb_addr[RegAw-1:0]] <= wb_data;
      end
   end

   assign dbg_data  = shadow_q[dbg_addr];
   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
   assign halted    = halted_q;

`ifdef CORE_MON_TRACE_EN
   logic [2*XLEN-1:0] tr_data;

   mon_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * XLEN)
   ) u_fifo (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (capture),
      .data_i     ({ret_pc, ret_ir}),
      .pop_i      (tr_ready),
      .valid_o    (tr_valid),
      .data_o     (tr_data),
      .overflow_o (tr_overflow)
   );

   assign tr_pc = tr_data[2*XLEN-1:XLEN];
   assign tr_ir = tr_data[XLEN-1:0];
`else
   logic unused_trace;
   assign unused_trace = tr_ready ^ capture;

   assign tr_valid    = 1'b0;
   assign tr_pc       = '0;
   assign tr_ir       = '0;
   assign tr_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_core_trace_monitor.sv
// Directed self-checking bench for core_trace_monitor; trace expectations follow
// whether CORE_MON_TRACE_EN is defined for the build.
module tb_core_trace_monitor;
   import core_mon_pkg::*;

`ifdef CORE_MON_TRACE_EN
   localparam bit TraceEn = 1'b1;
`else
   localparam bit TraceEn = 1'b0;
`endif

   localparam logic [31:0] Nop = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ret_valid = 1'b0;
   logic [31:0] ret_pc = '0;
   logic [31:0] ret_ir = '0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic [3:0]  dbg_addr = '0;
   logic [31:0] dbg_data;
   logic        tr_valid;
   logic        tr_ready = 1'b0;
   logic [31:0] tr_pc;
   logic [31:0] tr_ir;
   logic        tr_overflow;
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
   logic        halted;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] cyc_m = '0;
   logic [31:0] instr_m = '0;
   logic        halt_m = 1'b0;

   core_trace_monitor u_dut (
      .clk         (clk),
      .rst         (rst),
      .ret_valid   (ret_valid),
      .ret_pc      (ret_pc),
      .ret_ir      (ret_ir),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data),
      .tr_valid    (tr_valid),
      .tr_ready    (tr_ready),
      .tr_pc       (tr_pc),
      .tr_ir       (tr_ir),
      .tr_overflow (tr_overflow),
      .cycle_cnt   (cycle_cnt),
      .instr_cnt   (instr_cnt),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) cyc_m = '0;
      else if (!halt_m) cyc_m++;
      #1;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] ir, input logic we,
                         input logic [4:0] addr, input logic [31:0] data);
      ret_valid = 1'b1;
      ret_pc    = pc;
      ret_ir    = ir;
      wb_we     = we;
      wb_addr   = addr;
      wb_data   = data;
      if (!halt_m) instr_m++;
      step();
      ret_valid = 1'b0;
      wb_we     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst     = 1'b0;
      halt_m  = 1'b0;
      instr_m = '0;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_cycle"}, cycle_cnt, 0);
      check_eq({tag, "_instr"}, instr_cnt, 0);
      check_eq({tag, "_halted"}, halted, 0);
      check_eq({tag, "_tr_valid"}, tr_valid, 0);
      check_eq({tag, "_tr_pc"}, tr_pc, 0);
      check_eq({tag, "_tr_ir"}, tr_ir, 0);
      check_eq({tag, "_tr_ovf"}, tr_overflow, 0);
   endtask

   task automatic read_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      dbg_addr = addr;
      step();
      check_eq(tag, dbg_data, exp);
   endtask

   task automatic pop_check(input string tag, input logic [31:0] pc, input logic [31:0] ir);
      check_eq({tag, "_valid"}, tr_valid, 1);
      check_eq({tag, "_pc"}, tr_pc, pc);
      check_eq({tag, "_ir"}, tr_ir, ir);
      tr_ready = 1'b1;
      step();
      tr_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_pc;
      int          n_pop;

      // Reset and idle counting
      do_reset();
      check_reset("rst0");
      read_reg("rst0_x1", 4'd1, 32'd0);
      for (int i = 0; i < 9; i++) step();
      check_eq("idle_cycle", cycle_cnt, 32'd10);
      check_eq("idle_instr", instr_cnt, 0);
      check_eq("idle_tr_valid", tr_valid, 0);
      check_eq("idle_halted", halted, 0);

      // Basic retirement with register writes
      retire(32'h0, Nop, 1'b1, 5'd1, 32'd5);
      retire(32'h4, Nop, 1'b1, 5'd20, 32'd7);
      retire(32'h8, Nop, 1'b1, 5'd0, 32'd9);
      check_eq("basic_instr", instr_cnt, 32'd3);
      check_eq("basic_cycle", cycle_cnt, cyc_m);
      read_reg("shadow_x1", 4'd1, 32'd5);
      read_reg("shadow_x0", 4'd0, 32'd0);
      read_reg("shadow_x4_no_alias", 4'd4, 32'd0);
`ifdef CORE_MON_TRACE_EN
      pop_check("pop0", 32'h0, Nop);
      pop_check("pop1", 32'h4, Nop);
      pop_check("pop2", 32'h8, Nop);
`endif
      check_eq("basic_drained", tr_valid, 0);

      // Overflow: 20 pushes into a 16-deep FIFO with no pops
      for (int i = 0; i < 20; i++) begin
         retire(32'h100 + 32'(4 * i), Nop, 1'b0, 5'd0, 32'd0);
         if (i == 15) check_eq("ovf_at_full", tr_overflow, 0);
      end
      check_eq("ovf_set", tr_overflow, TraceEn);
      check_eq("ovf_head_kept", tr_pc, TraceEn ? 32'h100 : 32'h0);
      check_eq("ovf_instr", instr_cnt, instr_m);
      tr_ready = 1'b1;
      retire(32'h200, Nop, 1'b0, 5'd0, 32'd0);
      tr_ready = 1'b0;
      check_eq("ovf_sticky", tr_overflow, TraceEn);
`ifdef CORE_MON_TRACE_EN
      n_pop = 0;
      for (int k = 0; k < 40 && tr_valid; k++) begin
         exp_pc = (n_pop < 15) ? 32'h104 + 32'(4 * n_pop) : 32'h200;
         check_eq("ovf_drain_pc", tr_pc, exp_pc);
         n_pop++;
         tr_ready = 1'b1;
         step();
         tr_ready = 1'b0;
      end
      check_eq("ovf_occupancy", n_pop, 16);
`endif

      // Halt by repeated PC; an intervening PC restarts the run
      retire(32'h40, Nop, 1'b1, 5'd3, 32'hAB);
      retire(32'h40, Nop, 1'b0, 5'd0, 32'd0);
      retire(32'h40, Nop, 1'b0, 5'd0, 32'd0);
      retire(32'h44, Nop, 1'b0, 5'd0, 32'd0);
      check_eq("loop_break_nohalt", halted, 0);
      retire(32'h40, Nop, 1'b0, 5'd0, 32'd0);
      retire(32'h40, Nop, 1'b0, 5'd0, 32'd0);
      retire(32'h40, Nop, 1'b0, 5'd0, 32'd0);
      check_eq("loop3_nohalt", halted, 0);
      retire(32'h40, Nop, 1'b0, 5'd0, 32'd0);
      halt_m = 1'b1;
      check_eq("loop4_halted", halted, 1);
      check_eq("loop_instr", instr_cnt, instr_m);
      retire(32'h48, Nop, 1'b1, 5'd2, 32'h55);
      step();
      step();
      check_eq("halt_instr_frozen", instr_cnt, instr_m);
      check_eq("halt_cycle_frozen", cycle_cnt, cyc_m);
      read_reg("shadow_x3", 4'd3, 32'hAB);
      read_reg("shadow_x2_frozen", 4'd2, 32'd0);
`ifdef CORE_MON_TRACE_EN
      n_pop = 0;
      for (int k = 0; k < 20 && tr_valid; k++) begin
         exp_pc = (n_pop == 3) ? 32'h44 : 32'h40;
         check_eq("halt_drain_pc", tr_pc, exp_pc);
         n_pop++;
         tr_ready = 1'b1;
         step();
         tr_ready = 1'b0;
      end
      check_eq("halt_trace_count", n_pop, 8);
`endif

      // Reset while halted (overflow still set in a trace build)
      do_reset();
      check_reset("rst1");
      read_reg("rst1_x3", 4'd3, 32'd0);

      // ECALL does not halt; EBREAK does and is traced
      retire(32'h7C, ECALL, 1'b0, 5'd0, 32'd0);
      check_eq("ecall_nohalt", halted, 0);
      retire(32'h80, Nop, 1'b0, 5'd0, 32'd0);
      check_eq("pre_ebreak_nohalt", halted, 0);
      retire(32'h84, EBREAK, 1'b0, 5'd0, 32'd0);
      halt_m = 1'b1;
      check_eq("ebreak_halted", halted, 1);
      check_eq("ebreak_instr", instr_cnt, 32'd3);
      check_eq("ebreak_cycle", cycle_cnt, cyc_m);
`ifdef CORE_MON_TRACE_EN
      pop_check("eb0", 32'h7C, ECALL);
      pop_check("eb1", 32'h80, Nop);
      check_eq("eb_head_pc", tr_pc, 32'h84);
      check_eq("eb_head_ir", tr_ir, EBREAK);
`endif

      // Reset with a non-empty FIFO and halt set
      do_reset();
      check_reset("rst2");

      // Five retirements: instret and trace presence
      for (int i = 0; i < 5; i++) retire(32'h300 + 32'(4 * i), Nop, 1'b0, 5'd0, 32'd0);
      check_eq("five_instr", instr_cnt, 32'd5);
      check_eq("five_tr_valid", tr_valid, TraceEn);
      check_eq("five_cycle", cycle_cnt, cyc_m);
      check_eq("five_halted", halted, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_trace_monitor.md
Name: core_trace_monitor

Overview:
Synthesizable observability block attached to the core's retire stage. It keeps cycle and retired-instruction counters and a shadow copy of the first NREG general-purpose registers, fed by snooping register-file writes. It detects program halt and buffers a PC/IR trace in a FIFO that a debug host or testbench drains. It replaces ad-hoc hierarchical peeking into core internals with a fixed port-level interface.

Parameters:
XLEN, 32, data/PC/IR width
NREG, 16, shadow registers x0..x(NREG-1); power of 2, range 2..32
DEPTH, 16, trace FIFO entries; power of 2, range 2..256
CNT_W, 32, width of cycle and instruction counters
HALT_LOOP, 4, consecutive retirements at the same PC that signal a halt; range 2..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ret_valid  in  1  one instruction retires this cycle
ret_pc  in  XLEN  PC of the retiring instruction
ret_ir  in  XLEN  instruction word of the retiring instruction
wb_we  in  1  register-file write enable
wb_addr  in  5  register-file write address
wb_data  in  XLEN  register-file write data
dbg_addr  in  log2(NREG)  shadow-register read address
dbg_data  out  XLEN  shadow-register read data (combinational)
tr_valid  out  1  trace FIFO not empty
tr_ready  in  1  host pops the trace FIFO
tr_pc  out  XLEN  PC at the FIFO head
tr_ir  out  XLEN  IR at the FIFO head
tr_overflow  out  1  sticky flag: at least one trace entry was dropped
cycle_cnt  out  CNT_W  cycles since reset
instr_cnt  out  CNT_W  instructions retired since reset
halted  out  1  sticky halt flag

Behaviour:
- Reset values: all shadow registers 0; cycle_cnt, instr_cnt 0; halted 0; tr_overflow 0; FIFO empty (tr_valid 0, tr_pc and tr_ir 0); repeat counter and last-PC register 0.
- Reset is honoured in any state, including mid-halt or with a full FIFO. The reset cycle performs no counting, capture or pop.
- cycle_cnt: +1 every non-reset cycle while halted==0. Wraps modulo 2^CNT_W.
- instr_cnt: +1 on each ret_valid while halted==0. Wraps modulo 2^CNT_W.
- Shadow regs: write when wb_we && wb_addr!=0 && wb_addr<NREG && halted==0.
  - A write is visible on dbg_data the next cycle; there is no same-cycle bypass.
  - Writes with wb_addr>=NREG are ignored.
  - Shadow x0 always reads 0.
- Halt detection (only when ret_valid && halted==0):
  - ret_ir==EBREAK (0x00100073) sets halted next cycle. The EBREAK itself is counted and traced.
  - Repeat counter: set to 1 when ret_pc != last PC; incremented when ret_pc == last PC. The first retirement after reset always counts as a new PC.
  - When the counter reaches HALT_LOOP, halted is set. That retirement is counted and traced.
- While halted==1: counters and shadow regs freeze; trace capture stops; popping still works.
- Trace FIFO (first-word-fall-through):
  - Push on ret_valid && halted==0. Pop on tr_valid && tr_ready.
  - Full and no pop: the incoming entry is dropped and tr_overflow set. The existing FIFO contents are kept.
  - Full with simultaneous pop: the push is accepted, no drop, occupancy stays DEPTH.
  - Empty with simultaneous push: the entry appears on tr_* the next cycle. Pop is ignored while empty.
  - Read and write pointers are log2(DEPTH)+1 bits and wrap naturally. Full and empty are decided from the MSB compare.
- tr_overflow clears only on reset.

Optional Feature:
Macro CORE_MON_TRACE_EN.
- Defined: trace FIFO present, behaviour as above.
- Undefined: no FIFO storage is built; tr_valid, tr_pc, tr_ir and tr_overflow are tied to 0 and tr_ready is ignored. Counters, shadow regs and halt detection are unchanged.

Decomposition:
- Shared package core_mon_pkg holds:
  - EBREAK and ECALL encodings
  - a trace-entry typedef {pc, ir} of 2*XLEN bits
  - the default XLEN and CNT_W values
- One sub-module: mon_fifo, a parametrised DEPTH×width FWFT FIFO with the drop-on-full rule.
  - Instantiated only under CORE_MON_TRACE_EN.

Test Plan:
- Reset, then 10 idle cycles → cycle_cnt=10, instr_cnt=0, tr_valid=0, halted=0.
- Retire PCs 0x0, 0x4, 0x8 with wb writes x1=5, x20=7, x0=9 → instr_cnt=3; dbg_addr=1 gives 5; x0 reads 0; x20 write ignored at NREG=16; trace pops return 0x0, 0x4, 0x8 in order.
- Retire 20 instructions with tr_ready=0, DEPTH=16 → first 16 entries kept, tr_overflow=1. Then retire 1 with tr_ready=1 on a full FIFO → no further drop, occupancy 16.
- Retire ret_pc=0x40 four consecutive times (HALT_LOOP=4) → halted=1 after the 4th, instr_cnt stops at its value; a further ret_valid is not traced; cycle_cnt frozen.
- Retire ret_ir=0x00100073 → halted next cycle, the EBREAK is present in the trace. Assert rst for 1 cycle → all outputs return to reset values.
- Build without CORE_MON_TRACE_EN, retire 5 instructions → tr_valid stays 0 and instr_cnt=5.
